lamp_status_decoder: RTL and testbench
======================================

// Module: lamp_status_decoder
// PURPOSE
//  Observer for the water_lamp output bus: reads ledL/ledR flasher patterns and the two 7-segment digits,
//  recovers what the lamp controller is doing per side (off, sweep, blink, steady, fault), the step period,
//  and the BCD digit values. Sits beside water_lamp on the board or bench as its read-back / self-check end.
// PARAMETERS
//  STABLE_CYC  4      consecutive equal samples before an input change is accepted (glitch filter, >=1)
//  TIMEOUT     1024   cycles without an accepted change before a side falls back to a static mode
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   asynchronous, active-high reset
//  ledL        in   3   left flasher LEDs, bit0 innermost
//  ledR        in   3   right flasher LEDs, bit0 innermost
//  ledNum1     in   7   digit 1 segments {g,f,e,d,c,b,a}, active-high
//  ledNum2     in   7   digit 2 segments, same encoding
//  modeL       out  3   left mode: 0 IDLE, 1 SWEEP, 2 BLINK, 3 STEADY_ON, 4 FAULT
//  modeR       out  3   right mode, same coding
//  periodL     out  16  cycles between the last two accepted left changes, saturates at 16'hFFFF
//  periodR     out  16  same for right
//  digit1      out  4   decoded digit 1: 0-9, 4'hE blank, 4'hF invalid
//  digit2      out  4   decoded digit 2, same coding
//  digit_err   out  1   high while either digit decodes to 4'hF
// BEHAVIOUR
//  Reset: all outputs 0 (modes IDLE, periods 0, digits 0, digit_err 0); filters, run counters, timers cleared.
//  Input path: every input registered once; per field (ledL, ledR, ledNum1, ledNum2) a filter counter
//   accepts a new value when the registered sample has been equal for STABLE_CYC consecutive cycles.
//   Input change to decoded/updated output = STABLE_CYC+2 cycles; pulses shorter than STABLE_CYC ignored.
//  7-seg decode (registered): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9 00=E, any other=F.
//  Per-side FSM, evaluated on each accepted pattern change (old->new):
//   sweep step: 000->001, 001->011, 011->111; increments sweep_run (sat 3), clears blink_run.
//   blink step: 000->111; increments blink_run (sat 3), clears sweep_run.
//   neutral:    111->000; state and run counters unchanged.
//   any other change, or new pattern in {010,100,101,110}: state FAULT, both runs cleared.
//   sweep_run reaching 2 -> SWEEP; blink_run reaching 2 -> BLINK; otherwise state held.
//  Period: per-side counter cleared on each accepted change, +1 per cycle, saturating; on an accepted change
//   periodX <= counter+1 (saturating). Changes every N cycles -> periodX = N.
//  Timeout: counter reaching TIMEOUT-1 with no accepted change -> mode from held pattern: 000 IDLE,
//   111 STEADY_ON, else FAULT; runs cleared; periodX unchanged; re-evaluated only after next change.
//  Simultaneous: accepted change and timeout on the same cycle -> change wins. Left/right fully independent.
//  Reset mid-operation: immediate return to reset values; first post-reset pattern is not a change unless
//   it differs from 000 (compared against reset value 000).
// TESTING
//  rst high then low, all inputs 0 -> all outputs 0, modeL/modeR IDLE, no change after 2*TIMEOUT cycles.
//  ledL stepped 000,001,011,111,000,001 every 20 cycles -> modeL=1 after 2nd step, periodL=20, modeR=0.
//  ledR toggled 000/111 every 50 cycles -> modeR=2 after 2nd 000->111, periodR=50.
//  ledL=001 for STABLE_CYC-1 cycles then back to 000 -> no accepted change, modeL and periodL unchanged.
//  ledNum1=7'h6D, ledNum2=7'h12 -> digit1=5, digit2=F, digit_err=1 at STABLE_CYC+2 cycles; ledNum2=00 -> E, err 0.
//  ledL held 111 during SWEEP for TIMEOUT cycles -> modeL=3; ledL=010 -> modeL=4; rst pulse mid-sweep -> all 0.

Source files
------------

// File: rtl/lamp_status_decoder.sv
// rtl/lamp_status_decoder.sv - read-back observer for the water_lamp flasher and 7-segment outputs
// Glitch-filters each output field, classifies each flasher side's behaviour and decodes both digits.

module lamp_status_filter #(
    parameter int W          = 3,
    parameter int STABLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] val_o,
    output logic [W-1:0] prev_o,
    output logic         chg_o
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [W-1:0]  sample_q, last_q, val_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chg_q, accept;

    // cnt_d counts how many consecutive cycles sample_q has held its present value
    always_comb begin
        cnt_d = cnt_q;
        if (sample_q != last_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q < CW'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign accept = (cnt_d == CW'(STABLE_CYC)) && (sample_q != val_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            last_q   <= '0;
            val_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            sample_q <= din_i;
            last_q   <= sample_q;
            cnt_q    <= cnt_d;
            chg_q    <= accept;
            if (accept) begin
                prev_q <= val_q;
                val_q  <= sample_q;
            end
        end
    end

    assign val_o  = val_q;
    assign prev_o = prev_q;
    assign chg_o  = chg_q;
endmodule

module lamp_status_side #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chg_i,
    input  logic [2:0]  old_i,
    input  logic [2:0]  new_i,
    output logic [2:0]  mode_o,
    output logic [15:0] period_o
);
    localparam logic [2:0]  IDLE      = 3'd0;
    localparam logic [2:0]  SWEEP     = 3'd1;
    localparam logic [2:0]  BLINK     = 3'd2;
    localparam logic [2:0]  STEADY_ON = 3'd3;
    localparam logic [2:0]  FAULT     = 3'd4;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    logic [2:0]  mode_q, mode_d;
    logic [1:0]  sweep_q, sweep_d, blink_q, blink_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
    logic        sweep_step, blink_step, neutral_step, bad_pat;

    assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign sweep_step   = (old_i == 3'b000 && new_i == 3'b001) ||
                          (old_i == 3'b001 && new_i == 3'b011) ||
                          (old_i == 3'b011 && new_i == 3'b111);
    assign blink_step   = (old_i == 3'b000 && new_i == 3'b111);
    assign neutral_step = (old_i == 3'b111 && new_i == 3'b000);
    assign bad_pat      = new_i inside {3'b010, 3'b100, 3'b101, 3'b110};

    always_comb begin
        mode_d   = mode_q;
        sweep_d  = sweep_q;
        blink_d  = blink_q;
        period_d = period_q;
        cnt_d    = cnt_inc;
        if (chg_i) begin
            cnt_d    = 16'd0;
            period_d = cnt_inc;
            if (bad_pat) begin
                mode_d  = FAULT;
                sweep_d = 2'd0;
                blink_d = 2'd0;
            end else if (sweep_step) begin
                sweep_d = (sweep_q == 2'd3) ? 2'd3 : sweep_q + 2'd1;
                blink_d = 2'd0;
                if (sweep_q == 2'd1) mode_d = SWEEP;
            end else if (blink_step) begin
                blink_d = (blink_q == 2'd3) ? 2'd3 : blink_q + 2'd1;
                sweep_d = 2'd0;
                if (blink_q == 2'd1) mode_d = BLINK;
            end else if (!neutral_step) begin
                mode_d  = FAULT;
                sweep_d = 2'd0;
                blink_d = 2'd0;
            end
        end else if (cnt_q == TO_LAST) begin
            // Activity stopped: classify the pattern the lamp is parked on
            mode_d  = (new_i == 3'b000) ? IDLE : (new_i == 3'b111) ? STEADY_ON : FAULT;
            sweep_d = 2'd0;
            blink_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= IDLE;
            sweep_q  <= 2'd0;
            blink_q  <= 2'd0;
            cnt_q    <= 16'd0;
            period_q <= 16'd0;
        end else begin
            mode_q   <= mode_d;
            sweep_q  <= sweep_d;
            blink_q  <= blink_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign mode_o   = mode_q;
    assign period_o = period_q;
endmodule

module lamp_status_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ledL,
    input  logic [2:0]  ledR,
    input  logic [6:0]  ledNum1,
    input  logic [6:0]  ledNum2,
    output logic [2:0]  modeL,
    output logic [2:0]  modeR,
    output logic [15:0] periodL,
    output logic [15:0] periodR,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic        digit_err
);
    logic [2:0] l_val, l_prev, r_val, r_prev;
    logic [6:0] n1_val, n1_prev, n2_val, n2_prev;
    logic       l_chg, r_chg, n1_chg, n2_chg;
    logic [3:0] digit1_q, digit2_q;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h3F:   return 4'd0;
            7'h06:   return 4'd1;
            7'h5B:   return 4'd2;
            7'h4F:   return 4'd3;
            7'h66:   return 4'd4;
            7'h6D:   return 4'd5;
            7'h7D:   return 4'd6;
            7'h07:   return 4'd7;
            7'h7F:   return 4'd8;
            7'h6F:   return 4'd9;
            7'h00:   return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    lamp_status_filter #(.W(3), .STABLE_CYC(STABLE_CYC)) u_flt_l (
        .clk(clk), .rst(rst), .din_i(ledL), .val_o(l_val), .prev_o(l_prev), .chg_o(l_chg));
    lamp_status_filter #(.W(3), .STABLE_CYC(STABLE_CYC)) u_flt_r (
        .clk(clk), .rst(rst), .din_i(ledR), .val_o(r_val), .prev_o(r_prev), .chg_o(r_chg));
    lamp_status_filter #(.W(7), .STABLE_CYC(STABLE_CYC)) u_flt_n1 (
        .clk(clk), .rst(rst), .din_i(ledNum1), .val_o(n1_val), .prev_o(n1_prev), .chg_o(n1_chg));
    lamp_status_filter #(.W(7), .STABLE_CYC(STABLE_CYC)) u_flt_n2 (
        .clk(clk), .rst(rst), .din_i(ledNum2), .val_o(n2_val), .prev_o(n2_prev), .chg_o(n2_chg));

    lamp_status_side #(.TIMEOUT(TIMEOUT)) u_side_l (
        .clk(clk), .rst(rst), .chg_i(l_chg), .old_i(l_prev), .new_i(l_val),
        .mode_o(modeL), .period_o(periodL));
    lamp_status_side #(.TIMEOUT(TIMEOUT)) u_side_r (
        .clk(clk), .rst(rst), .chg_i(r_chg), .old_i(r_prev), .new_i(r_val),
        .mode_o(modeR), .period_o(periodR));

    // Digits only move on an accepted change so a blank display after reset still reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit1_q <= 4'd0;
            digit2_q <= 4'd0;
        end else begin
            if (n1_chg) digit1_q <= seg_decode(n1_val);
            if (n2_chg) digit2_q <= seg_decode(n2_val);
        end
    end

    assign digit1    = digit1_q;
    assign digit2    = digit2_q;
    assign digit_err = (digit1_q == 4'hF) || (digit2_q == 4'hF);
endmodule

// File: tb/tb_lamp_status_decoder.sv
// tb/tb_lamp_status_decoder.sv - directed self-checking bench for lamp_status_decoder

module tb_lamp_status_decoder;
    logic        clk;
    logic        rst;
    logic [2:0]  ledL, ledR;
    logic [6:0]  ledNum1, ledNum2;
    logic [2:0]  modeL, modeR;
    logic [15:0] periodL, periodR;
    logic [3:0]  digit1, digit2;
    logic        digit_err;
    int          total = 0;
    int          bad   = 0;

    lamp_status_decoder #(.STABLE_CYC(4), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .ledL(ledL), .ledR(ledR),
        .ledNum1(ledNum1), .ledNum2(ledNum2),
        .modeL(modeL), .modeR(modeR), .periodL(periodL), .periodR(periodR),
        .digit1(digit1), .digit2(digit2), .digit_err(digit_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ledL = 3'b000; ledR = 3'b000; ledNum1 = 7'h00; ledNum2 = 7'h00;
        tick(3);
        chk("rst_modeL", 16'(modeL), 16'd0);
        chk("rst_periodL", periodL, 16'd0);
        chk("rst_digit1", 16'(digit1), 16'd0);
        rst = 1'b0;
        tick(2);
        chk("post_rst_modeR", 16'(modeR), 16'd0);
        chk("post_rst_digit2", 16'(digit2), 16'd0);
        chk("post_rst_err", 16'(digit_err), 16'd0);

        tick(2048);
        chk("idle_modeL", 16'(modeL), 16'd0);
        chk("idle_modeR", 16'(modeR), 16'd0);
        chk("idle_periodL", periodL, 16'd0);
        chk("idle_periodR", periodR, 16'd0);
        chk("idle_digit1", 16'(digit1), 16'd0);

        // left sweep every 20 cycles
        ledL = 3'b001; tick(6);
        chk("sw1_modeL", 16'(modeL), 16'd0);
        tick(14);
        ledL = 3'b011; tick(5);
        chk("sw2_latency_modeL", 16'(modeL), 16'd0);
        tick(1);
        chk("sw2_modeL", 16'(modeL), 16'd1);
        chk("sw2_periodL", periodL, 16'd20);
        tick(14);
        ledL = 3'b111; tick(20);
        chk("sw3_modeL", 16'(modeL), 16'd1);
        ledL = 3'b000; tick(20);
        chk("sw_neutral_modeL", 16'(modeL), 16'd1);
        ledL = 3'b001; tick(6);
        chk("sw5_modeL", 16'(modeL), 16'd1);
        chk("sw5_periodL", periodL, 16'd20);
        chk("sw5_modeR", 16'(modeR), 16'd0);
        tick(14);

        // glitch shorter than the filter window
        ledL = 3'b011; tick(3);
        ledL = 3'b001; tick(10);
        chk("glitch_modeL", 16'(modeL), 16'd1);
        chk("glitch_periodL", periodL, 16'd20);

        // park on 111 until timeout
        ledL = 3'b011; tick(20);
        ledL = 3'b111; tick(6);
        chk("park_modeL", 16'(modeL), 16'd1);
        tick(1023);
        chk("pre_timeout_modeL", 16'(modeL), 16'd1);
        tick(1);
        chk("timeout_modeL", 16'(modeL), 16'd3);
        chk("timeout_periodL", periodL, 16'd20);

        ledL = 3'b010; tick(6);
        chk("fault_modeL", 16'(modeL), 16'd4);

        // right blink every 50 cycles
        ledR = 3'b111; tick(6);
        chk("bl1_modeR", 16'(modeR), 16'd0);
        tick(44);
        ledR = 3'b000; tick(50);
        ledR = 3'b111; tick(6);
        chk("bl2_modeR", 16'(modeR), 16'd2);
        chk("bl2_periodR", periodR, 16'd50);
        chk("bl2_modeL", 16'(modeL), 16'd4);

        // digits
        ledNum1 = 7'h6D; ledNum2 = 7'h12; tick(5);
        chk("dig_latency_digit1", 16'(digit1), 16'd0);
        tick(1);
        chk("dig_digit1", 16'(digit1), 16'd5);
        chk("dig_digit2", 16'(digit2), 16'hF);
        chk("dig_err", 16'(digit_err), 16'd1);
        ledNum2 = 7'h00; ledNum1 = 7'h7F; tick(6);
        chk("blank_digit2", 16'(digit2), 16'hE);
        chk("blank_digit1", 16'(digit1), 16'd8);
        chk("blank_err", 16'(digit_err), 16'd0);

        // reset mid-sweep
        ledL = 3'b000; tick(20);
        ledL = 3'b001; tick(20);
        ledL = 3'b011; tick(6);
        chk("pre_rst_modeL", 16'(modeL), 16'd1);
        rst = 1'b1; #1;
        chk("midrst_modeL", 16'(modeL), 16'd0);
        chk("midrst_periodL", periodL, 16'd0);
        chk("midrst_modeR", 16'(modeR), 16'd0);
        chk("midrst_digit1", 16'(digit1), 16'd0);
        chk("midrst_err", 16'(digit_err), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(8);
        chk("post_rst_first_modeL", 16'(modeL), 16'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
